conv_window_feeder: RTL and testbench
=====================================

# conv_window_feeder

Streaming front end for the convolution engine: accepts a byte stream over a valid/ready handshake, fills a 3x3 kernel buffer and two 3x3 window buffers, pulses the engine's start, then serves the engine's kernel and window reads until the engine reports done. It is the writer and responder on the other side of the engine's kernel/window read interface. It sits between the DMA/host stream and the convolution engine.

## Interface
- KERNEL_SIZE, 3, kernel edge; buffers hold KERNEL_SIZE*KERNEL_SIZE (N) entries
- DATA_WIDTH, 8, element width
- SRAM_ADDR_WIDTH, 4, window read address width
- i_clk  in  1  sole clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_s_valid  in  1  stream beat valid
- i_s_data  in  DATA_WIDTH  stream beat payload
- o_s_ready  out  1  feeder accepts beat
- i_reload_kernel  in  1  sampled on first accepted beat of a frame; 1 = frame carries kernel
- o_start  out  1  one-cycle start pulse to engine
- i_done  in  1  engine completion
- i_kernel_addr  in  6  engine kernel read address
- o_kernel_data  out  DATA_WIDTH  kernel[i_kernel_addr]
- i_window_addr  in  SRAM_ADDR_WIDTH  engine window read address
- o_window1_data  out  DATA_WIDTH  window1[i_window_addr]
- o_window2_data  out  DATA_WIDTH  window2[i_window_addr]
- o_busy  out  1  high in any state other than IDLE
- o_frame_done  out  1  one-cycle pulse when the engine reports done
- o_err  out  1  sticky: frame began with i_reload_kernel=0 and no valid kernel; cleared by reset only

## Operation
- States: IDLE, LOAD_KERNEL, LOAD_W1, LOAD_W2, START, WAIT_DONE.
- IDLE: o_s_ready=1. On an accepted beat: if i_reload_kernel=1, the beat is kernel[0] and the next state is LOAD_KERNEL. If i_reload_kernel=0 and kernel_valid=1, the beat is window1[0] and the next state is LOAD_W1. If i_reload_kernel=0 and kernel_valid=0, the beat is dropped, o_err is set, and the state stays IDLE.
- LOAD_KERNEL / LOAD_W1 / LOAD_W2: o_s_ready=1. Beat counter idx runs 0..N-1. Each accepted beat writes buf[idx] and increments idx.
  - When beat N-1 is accepted, idx returns to 0 and the state advances: KERNEL→W1, W1→W2, W2→START.
  - Completing LOAD_KERNEL sets kernel_valid.
  - Cycles with no beat (valid low) hold all state.
- START: o_s_ready=0, o_start=1 for exactly this cycle, then WAIT_DONE.
- WAIT_DONE: o_s_ready=0. i_done=1 → o_frame_done pulses that cycle (combinational from state and i_done) and the next state is IDLE. i_done outside WAIT_DONE is ignored.
- Read ports are asynchronous (combinational): data corresponds to the address in the same cycle. They are valid in every state.
- An address ≥ N reads 0 on the corresponding data port.
- Buffers are written only by accepted beats; they are never cleared. kernel_valid is cleared by reset only.
- Reset: state=IDLE, idx=0, kernel_valid=0, o_err=0, o_start=0, o_frame_done=0, o_busy=0, o_s_ready=1 (follows from IDLE). Buffer contents are unspecified after reset.
- A reset mid-load abandons the partial frame. The next frame must carry a kernel or it raises o_err.

## Timing
- Beat accepted when i_s_valid & o_s_ready at a rising edge; write lands that edge.
- Full frame with kernel: 3N=27 beats. Without kernel: 2N=18 beats.
- o_start is asserted the cycle after the final window2 beat is accepted. The engine may read window2[N-1] in that cycle and sees the new value.
- o_busy rises the cycle after the first accepted beat. It falls the cycle after i_done is seen in WAIT_DONE.
- o_s_ready is a pure state decode; it has no combinational path from i_s_valid.
- Back-to-back frames: a beat offered in the cycle after i_done is accepted in IDLE.

## Structure
- Shared conv package: state encoding constants, KERNEL_SIZE/DATA_WIDTH defaults, N = KERNEL_SIZE*KERNEL_SIZE.
- One natural sub-module: conv_tap_buffer (N x DATA_WIDTH, one synchronous write port, one asynchronous read port returning 0 for addresses ≥ N), instantiated three times.

## Test plan
- Reset, then 27 beats 1..27 with reload=1, valid always high → o_start in cycle 28. Reads: kernel addr 0→1, addr 8→9; window1 addr 0→10; window2 addr 8→27.
- Second frame, reload=0, 18 beats 100..117 → kernel still reads 1..9; window1 addr 0→100; o_start after the 18th beat.
- First frame after reset with reload=0 → o_err=1, state stays IDLE, o_busy stays 0.
- i_s_valid toggled every other cycle across 27 beats → same buffer contents as the first scenario; o_start only after beat 27.
- i_done pulsed during a load and during START → ignored. i_done in WAIT_DONE → o_frame_done pulse, IDLE next cycle, and a beat in the following cycle is accepted.
- i_rst asserted after 13 beats → IDLE, kernel_valid=0; a subsequent 27-beat frame completes normally. Window read at addr 12 → 0.

Source files
------------

// File: rtl/conv_window_feeder_pkg.sv
// Shared conv definitions: geometry defaults and feeder state encoding.
package conv_window_feeder_pkg;

    localparam int unsigned CONV_KERNEL_SIZE     = 3;
    localparam int unsigned CONV_DATA_WIDTH      = 8;
    localparam int unsigned CONV_SRAM_ADDR_WIDTH = 4;
    localparam int unsigned CONV_KADDR_WIDTH     = 6;
    localparam int unsigned CONV_N               = CONV_KERNEL_SIZE * CONV_KERNEL_SIZE;
    localparam int unsigned CONV_IDX_WIDTH       = $clog2(CONV_N);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_KERNEL = 3'd1,
        ST_LOAD_W1     = 3'd2,
        ST_LOAD_W2     = 3'd3,
        ST_START       = 3'd4,
        ST_WAIT_DONE   = 3'd5
    } conv_state_t;

endpackage

// File: rtl/conv_tap_buffer.sv
// N-entry tap buffer: one synchronous write port, one asynchronous read port
// that returns zero for addresses past the last entry.
module conv_tap_buffer
    import conv_window_feeder_pkg::*;
#(
    parameter int unsigned DEPTH       = CONV_N,
    parameter int unsigned DATA_WIDTH  = CONV_DATA_WIDTH,
    parameter int unsigned IDX_WIDTH   = CONV_IDX_WIDTH,
    parameter int unsigned RADDR_WIDTH = CONV_SRAM_ADDR_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [IDX_WIDTH-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]  i_wdata,
    input  logic [RADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]  o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write lands on the accepting edge; contents are never cleared.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Combinational read, out-of-range addresses read as zero.
    always_comb begin
        o_rdata = '0;
        if (i_raddr < RADDR_WIDTH'(DEPTH)) begin
            o_rdata = mem_q[i_raddr[IDX_WIDTH-1:0]];
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Stream front end for the convolution engine: loads kernel and two windows
// from a valid/ready byte stream, starts the engine, serves its reads.
module conv_window_feeder
    import conv_window_feeder_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE     = CONV_KERNEL_SIZE,
    parameter int unsigned DATA_WIDTH      = CONV_DATA_WIDTH,
    parameter int unsigned SRAM_ADDR_WIDTH = CONV_SRAM_ADDR_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_s_valid,
    input  logic [DATA_WIDTH-1:0]      i_s_data,
    output logic                       o_s_ready,
    input  logic                       i_reload_kernel,
    output logic                       o_start,
    input  logic                       i_done,
    input  logic [5:0]                 i_kernel_addr,
    output logic [DATA_WIDTH-1:0]      o_kernel_data,
    input  logic [SRAM_ADDR_WIDTH-1:0] i_window_addr,
    output logic [DATA_WIDTH-1:0]      o_window1_data,
    output logic [DATA_WIDTH-1:0]      o_window2_data,
    output logic                       o_busy,
    output logic                       o_frame_done,
    output logic                       o_err
);

    localparam int unsigned N     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned IDX_W = $clog2(N);

    conv_state_t      state_q;
    logic [IDX_W-1:0] idx_q;
    logic             kernel_valid_q;
    logic             err_q;

    logic accept;
    logic last_beat;
    logic kernel_we;
    logic w1_we;
    logic w2_we;

    // Ready, start and busy are pure decodes of the registered state.
    assign o_s_ready    = (state_q == ST_IDLE) || (state_q == ST_LOAD_KERNEL) ||
                          (state_q == ST_LOAD_W1) || (state_q == ST_LOAD_W2);
    assign o_start      = (state_q == ST_START);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_frame_done = (state_q == ST_WAIT_DONE) && i_done;
    assign o_err        = err_q;

    assign accept    = i_s_valid && o_s_ready;
    assign last_beat = (idx_q == IDX_W'(N - 1));

    // idx_q is always 0 in IDLE, so the first beat lands in entry 0.
    assign kernel_we = accept && (((state_q == ST_IDLE) && i_reload_kernel) ||
                                  (state_q == ST_LOAD_KERNEL));
    assign w1_we     = accept && (((state_q == ST_IDLE) && !i_reload_kernel && kernel_valid_q) ||
                                  (state_q == ST_LOAD_W1));
    assign w2_we     = accept && (state_q == ST_LOAD_W2);

    // Frame sequencing: beat counting, kernel validity and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            kernel_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (i_reload_kernel) begin
                            state_q <= ST_LOAD_KERNEL;
                            idx_q   <= IDX_W'(1);
                        end else if (kernel_valid_q) begin
                            state_q <= ST_LOAD_W1;
                            idx_q   <= IDX_W'(1);
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_LOAD_KERNEL, ST_LOAD_W1, ST_LOAD_W2: begin
                    if (accept) begin
                        if (last_beat) begin
                            idx_q <= '0;
                            case (state_q)
                                ST_LOAD_KERNEL: begin
                                    state_q        <= ST_LOAD_W1;
                                    kernel_valid_q <= 1'b1;
                                end
                                ST_LOAD_W1: state_q <= ST_LOAD_W2;
                                default:    state_q <= ST_START;
                            endcase
                        end else begin
                            idx_q <= IDX_W'(idx_q + 1'b1);
                        end
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (i_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    conv_tap_buffer #(
        .DEPTH(N), .DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_W), .RADDR_WIDTH(6)
    ) u_kernel_buf (
        .i_clk(i_clk), .i_we(kernel_we), .i_waddr(idx_q), .i_wdata(i_s_data),
        .i_raddr(i_kernel_addr), .o_rdata(o_kernel_data)
    );

    conv_tap_buffer #(
        .DEPTH(N), .DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_W), .RADDR_WIDTH(SRAM_ADDR_WIDTH)
    ) u_window1_buf (
        .i_clk(i_clk), .i_we(w1_we), .i_waddr(idx_q), .i_wdata(i_s_data),
        .i_raddr(i_window_addr), .o_rdata(o_window1_data)
    );

    conv_tap_buffer #(
        .DEPTH(N), .DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_W), .RADDR_WIDTH(SRAM_ADDR_WIDTH)
    ) u_window2_buf (
        .i_clk(i_clk), .i_we(w2_we), .i_waddr(idx_q), .i_wdata(i_s_data),
        .i_raddr(i_window_addr), .o_rdata(o_window2_data)
    );

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed + randomized bench for conv_window_feeder with a frame-level model.
module tb_conv_window_feeder;

    localparam int N = 9;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_s_valid;
    logic [7:0] i_s_data;
    logic       o_s_ready;
    logic       i_reload_kernel;
    logic       o_start;
    logic       i_done;
    logic [5:0] i_kernel_addr;
    logic [7:0] o_kernel_data;
    logic [3:0] i_window_addr;
    logic [7:0] o_window1_data;
    logic [7:0] o_window2_data;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_err;

    conv_window_feeder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
        .o_s_ready(o_s_ready), .i_reload_kernel(i_reload_kernel), .o_start(o_start),
        .i_done(i_done), .i_kernel_addr(i_kernel_addr), .o_kernel_data(o_kernel_data),
        .i_window_addr(i_window_addr), .o_window1_data(o_window1_data),
        .o_window2_data(o_window2_data), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // Reference model: buffer images and flags, updated per frame.
    logic [7:0] m_kernel [N];
    logic [7:0] m_w1 [N];
    logic [7:0] m_w2 [N];
    bit         m_kv;
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_s_valid = 1'b0;
        i_s_data = '0;
        i_reload_kernel = 1'b0;
        i_done = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        m_kv = 1'b0;
        m_err = 1'b0;
        #1;
        chk("rst_ready", o_s_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_start", o_start, 0);
        chk("rst_fdone", o_frame_done, 0);
        chk("rst_err", o_err, 0);
    endtask

    // Offers one beat in IDLE with no kernel loaded: expect drop and sticky error.
    task automatic err_beat();
        i_s_valid = 1'b1;
        i_s_data = 8'($urandom);
        i_reload_kernel = 1'b0;
        i_done = 1'b1;
        #1;
        chk("err_ready", o_s_ready, 1);
        chk("err_fdone_idle", o_frame_done, 0);
        @(negedge i_clk);
        idle_inputs();
        m_err = 1'b1;
        #1;
        chk("err_flag", o_err, 1);
        chk("err_busy", o_busy, 0);
        chk("err_ready_after", o_s_ready, 1);
    endtask

    // mode 0: valid always high, 1: alternating, 2: random gaps.
    task automatic send_frame(input bit reload, input int mode, input bit rnd_data,
                              input int base, input bit done_noise, input bit done_in_start);
        logic [7:0] d [3*N];
        int nbeats;
        int sent;
        int cyc;
        bit v;
        nbeats = reload ? 3 * N : 2 * N;
        for (int i = 0; i < nbeats; i++) d[i] = rnd_data ? 8'($urandom) : 8'(base + i);
        sent = 0;
        cyc = 0;
        while (sent < nbeats && cyc < 400) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            i_s_valid = v;
            i_s_data = v ? d[sent] : 8'($urandom);
            i_reload_kernel = (sent == 0) ? reload : 1'($urandom);
            i_done = done_noise ? 1'($urandom) : 1'b0;
            #1;
            chk("ld_ready", o_s_ready, 1);
            chk("ld_start", o_start, 0);
            chk("ld_busy", o_busy, (sent != 0) ? 1 : 0);
            chk("ld_fdone", o_frame_done, 0);
            @(negedge i_clk);
            if (v) sent++;
            cyc++;
        end
        chk("ld_timeout", sent, nbeats);
        if (mode == 0) chk("ld_cycles", cyc, nbeats);
        else if (mode == 1) chk("ld_cycles_toggle", cyc, 2 * nbeats - 1);
        if (reload) for (int i = 0; i < N; i++) m_kernel[i] = d[i];
        for (int i = 0; i < N; i++) begin
            m_w1[i] = d[nbeats - 2 * N + i];
            m_w2[i] = d[nbeats - N + i];
        end
        if (reload) m_kv = 1'b1;
        // START cycle
        i_s_valid = 1'b1;
        i_s_data = 8'($urandom);
        i_done = done_in_start;
        i_window_addr = 4'(N - 1);
        #1;
        chk("st_start", o_start, 1);
        chk("st_ready", o_s_ready, 0);
        chk("st_busy", o_busy, 1);
        chk("st_fdone", o_frame_done, 0);
        chk("st_w2_last", o_window2_data, m_w2[N-1]);
        @(negedge i_clk);
        idle_inputs();
    endtask

    // Holds the engine busy for a few cycles, then signals done.
    task automatic finish_frame(input int delay);
        for (int i = 0; i < delay; i++) begin
            i_s_valid = 1'($urandom);
            #1;
            chk("wd_busy", o_busy, 1);
            chk("wd_ready", o_s_ready, 0);
            chk("wd_start", o_start, 0);
            chk("wd_fdone", o_frame_done, 0);
            @(negedge i_clk);
        end
        i_s_valid = 1'b0;
        i_done = 1'b1;
        #1;
        chk("wd_fdone_pulse", o_frame_done, 1);
        @(negedge i_clk);
        i_done = 1'b0;
        #1;
        chk("post_busy", o_busy, 0);
        chk("post_ready", o_s_ready, 1);
        chk("post_fdone", o_frame_done, 0);
        chk("post_err", o_err, m_err);
    endtask

    task automatic check_reads();
        logic [5:0] ka [3];
        i_s_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            i_window_addr = 4'(a);
            i_kernel_addr = 6'(a);
            #1;
            chk("rd_w1", o_window1_data, (a < N) ? m_w1[a] : 8'h00);
            chk("rd_w2", o_window2_data, (a < N) ? m_w2[a] : 8'h00);
            chk("rd_k", o_kernel_data, (a < N) ? m_kernel[a] : 8'h00);
        end
        ka[0] = 6'd63;
        ka[1] = 6'd32;
        ka[2] = 6'(16 + $urandom_range(0, 47));
        for (int j = 0; j < 3; j++) begin
            i_kernel_addr = ka[j];
            #1;
            chk("rd_k_high", o_kernel_data, 0);
        end
    endtask

    initial begin
        idle_inputs();
        i_rst = 1'b1;
        i_kernel_addr = '0;
        i_window_addr = '0;
        @(negedge i_clk);

        // Reset, then a no-kernel frame raises the error and stays idle.
        do_reset();
        err_beat();

        // Frame with kernel, beats 1..27, valid always high; done seen in START ignored.
        send_frame(1'b1, 0, 1'b0, 1, 1'b0, 1'b1);
        finish_frame(3);
        check_reads();
        i_kernel_addr = 6'd8;
        i_window_addr = 4'd0;
        #1;
        chk("dir_k8", o_kernel_data, 9);
        chk("dir_w1_0", o_window1_data, 10);

        // Back-to-back frame without kernel, beats 100..117.
        send_frame(1'b0, 0, 1'b0, 100, 1'b0, 1'b0);
        finish_frame(1);
        check_reads();
        i_kernel_addr = 6'd0;
        i_window_addr = 4'd0;
        #1;
        chk("dir_k0_kept", o_kernel_data, 1);
        chk("dir_w1_100", o_window1_data, 100);

        // Toggled valid, done noise during load.
        send_frame(1'b1, 1, 1'b0, 1, 1'b1, 1'b0);
        finish_frame(2);
        check_reads();

        // Random frames with random gaps and reload choice.
        for (int f = 0; f < 4; f++) begin
            send_frame(1'($urandom), 2, 1'b1, 0, 1'b1, 1'($urandom));
            finish_frame($urandom_range(0, 4));
            check_reads();
        end

        // Reset after 13 beats abandons the frame and clears kernel validity.
        for (int i = 0; i < 13; i++) begin
            i_s_valid = 1'b1;
            i_s_data = 8'(200 + i);
            i_reload_kernel = 1'b1;
            @(negedge i_clk);
        end
        #1;
        chk("mid_busy", o_busy, 1);
        do_reset();
        err_beat();
        send_frame(1'b1, 2, 1'b1, 0, 1'b0, 1'b0);
        finish_frame(2);
        check_reads();
        i_window_addr = 4'd12;
        #1;
        chk("dir_w12_zero", o_window1_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
